stage_fetch_pq: RTL
===================

// Module: stage_fetch_pq
// PURPOSE
//  Prefetching fetch stage: parametrised successor to the single-entry fetch stage.
//  Keeps up to MAX_OUTSTANDING in-order memory requests in flight.
//  Buffers returned instructions with their PCs in a QDEPTH-entry queue, so decode stalls never block memory.
//  Redirects from the mem stage flush the queue and discard stale in-flight responses.
//  Sits between the mem-stage redirect/enable logic, the instruction memory port and decode.
// PARAMETERS
//  RESET_PC         32'h80000000  PC loaded on reset
//  QDEPTH           4             queue entries; power of 2, >=2
//  MAX_OUTSTANDING  2             max granted requests without a response; 1..QDEPTH
// PORTS
//  clk        in   1   clock, rising edge
//  reset_n    in   1   asynchronous active-low reset
//  de_stall   in   1   decode cannot accept de_insn this cycle
//  fe_enable  in   1   0: issue no new requests (in-flight ones still complete)
//  pc_wen     in   1   redirect: fetch from pc_in, discard everything older
//  pc_in      in   32  redirect target; bits [1:0] ignored (treated as 0)
//  fe_req     out  1   memory request valid
//  fe_addr    out  32  request address, word aligned
//  fe_gnt     in   1   request accepted this cycle (fe_req & fe_gnt)
//  fe_ack     in   1   response valid; responses in grant order, >=1 cycle after grant
//  fe_data    in   32  response instruction word
//  de_valid   out  1   queue head valid
//  de_insn    out  32  queue head instruction
//  de_pc      out  32  queue head PC
// BEHAVIOUR
//  - Reset (async assert, sync release): pc=RESET_PC; queue empty; outstanding=0; drop=0.
//    Outputs: fe_req=0, de_valid=0, de_insn=0, de_pc=0.
//  - cur_pc = pc_wen ? {pc_in[31:2],2'b0} : pc;  fe_addr = cur_pc.
//  - fe_req = fe_enable & (outstanding < MAX_OUTSTANDING) & (outstanding + count < QDEPTH).
//    This credit rule makes queue overflow impossible; dropped requests still hold credit.
//  - Grant: pc <= cur_pc + 4 (mod 2^32, FFFFFFFC -> 0); outstanding += 1.
//  - No grant: pc <= cur_pc, so a redirect without a grant is still latched.
//  - Ack: outstanding -= 1. If drop>0, the response is discarded and drop -= 1.
//    Otherwise push {pc_tag, fe_data}, where pc_tag comes from an in-order PC tag FIFO of granted addresses.
//    Grant and ack may occur in the same cycle; outstanding is unchanged.
//  - Redirect cycle (pc_wen=1):
//    - Queue flushed: count=0; de_valid is 0 from the next cycle.
//    - An ack in this cycle is discarded.
//    - drop <= outstanding - ack (old requests still to return).
//      If drop>0 and ack in the same cycle, the ack is consumed first.
//    - A grant in this cycle belongs to the new path; it is not counted in drop.
//    - Flush wins over a simultaneous push or pop.
//  - Output: de_valid = ~empty; de_insn/de_pc = head entry; all registered, no combinational path from fe_data.
//    Pop when de_valid & ~de_stall & ~pc_wen.
//  - Latency: ack in cycle N -> de_valid in cycle N+1 (queue empty, no flush).
//    Steady state: one instruction per cycle when the memory acks every cycle.
//  - Full queue: fe_req stays 0 until a pop frees a credit. Push and pop in the same cycle keep count.
//  - fe_enable=0 mid-stream: no new grants; pending acks still enqueue (unless dropped).
//  - Reset mid-operation: all state cleared immediately. Responses to pre-reset grants are the memory's responsibility to suppress.
// STRUCTURE
//  - riscv_pkg: RESET_PC default, fetch_entry_t {pc[31:0], insn[31:0]}, clog2 helper.
//  - Sub-module fetch_fifo #(WIDTH, DEPTH): sync FIFO with flush, push/pop, full/empty/count, async reset.
//    Instantiated twice: the PC tag FIFO (DEPTH=MAX_OUTSTANDING) and the instruction queue (DEPTH=QDEPTH).
//  - Top level: pc register, outstanding/drop counters, credit logic.
// TESTING
//  1. Reset release, memory acks 1 cycle after every grant, de_stall=0.
//     -> grants at 80000000, 80000004, ...; de_pc sequence identical; one de_valid per cycle.
//  2. de_stall=1 for 10 cycles, QDEPTH=4.
//     -> exactly 4 entries queued, fe_req=0 while full, no loss.
//     -> de_stall release drains 80000000..8000000C in order.
//  3. Two requests outstanding, pc_wen=1 with pc_in=80001002.
//     -> both stale acks discarded; next de_pc=80001000, then 80001004.
//  4. Redirect in the same cycle as an ack and a grant.
//     -> ack discarded, drop = outstanding-1, new-path grant's response enqueued.
//  5. pc=FFFFFFFC granted -> next fe_addr=00000000.
//  6. fe_enable=0 with 2 outstanding -> both complete and enqueue; fe_req stays 0.
//  7. Async reset asserted mid-burst -> de_valid/fe_req drop immediately; fetch restarts at 80000000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions.
//   RESET_PC_DEFAULT : PC loaded by the fetch stage on reset
//   fetch_entry_t    : one queued instruction with its PC
//   clog2            : ceiling log2 for sizing pointers and counters
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used for the PC tag FIFO and the instruction queue.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   flush_i        : empty the FIFO (wins over push/pop)
//   push_i, data_i : write an entry (accepted when not full, or when popping)
//   pop_i, data_o  : drop the head entry; data_o is the registered head
//   full_o, empty_o, count_o : occupancy
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            data_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= next_ptr(wr_q);
            end
            if (do_pop) begin
                rd_q <= next_ptr(rd_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/stage_fetch_pq.sv
// Prefetching fetch stage: keeps up to MAX_OUTSTANDING in-order requests in
// flight and buffers returned instructions with their PCs in a QDEPTH queue.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   de_stall, fe_enable          : decode back-pressure, request enable
//   pc_wen, pc_in                : redirect (flushes queue, drops stale responses)
//   fe_req, fe_addr, fe_gnt      : instruction memory request handshake
//   fe_ack, fe_data              : in-order memory responses
//   de_valid, de_insn, de_pc     : registered queue head towards decode
module stage_fetch_pq
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned QDEPTH          = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        de_stall,
    input  logic        fe_enable,
    input  logic        pc_wen,
    input  logic [31:0] pc_in,
    output logic        fe_req,
    output logic [31:0] fe_addr,
    input  logic        fe_gnt,
    input  logic        fe_ack,
    input  logic [31:0] fe_data,
    output logic        de_valid,
    output logic [31:0] de_insn,
    output logic [31:0] de_pc
);

    localparam int unsigned CW  = clog2(QDEPTH + 1);
    localparam int unsigned TCW = clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] OUT_LIMIT = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   Q_LIMIT   = (CW + 1)'(QDEPTH);

    logic [31:0]    pc_q, pc_d, cur_pc;
    logic [CW-1:0]  outst_q, outst_d;
    logic [CW-1:0]  drop_q, drop_d;
    logic [CW:0]    credit_used;
    logic           grant, drop_ack;
    logic           q_push, q_pop, q_empty, q_full;
    logic [CW-1:0]  q_count;
    fetch_entry_t   q_head, q_entry;
    logic [31:0]    tag_head;
    logic           tag_full, tag_empty;
    logic [TCW-1:0] tag_count;
    logic           unused_status;

    assign cur_pc  = pc_wen ? {pc_in[31:2], 2'b00} : pc_q;
    assign fe_addr = cur_pc;

    // Dropped-but-pending requests still occupy credit, so every granted
    // request is guaranteed a queue slot when its response arrives.
    assign credit_used = {1'b0, outst_q} + {1'b0, q_count};
    assign fe_req = reset_n & fe_enable & (outst_q < OUT_LIMIT) & (credit_used < Q_LIMIT);
    assign grant  = fe_req & fe_gnt;

    assign drop_ack = fe_ack & (drop_q != '0);
    assign q_push   = fe_ack & (drop_q == '0) & ~pc_wen;
    assign q_pop    = de_valid & ~de_stall & ~pc_wen;
    assign q_entry  = '{pc: tag_head, insn: fe_data};

    always_comb begin
        pc_d = grant ? cur_pc + 32'd4 : cur_pc;

        outst_d = outst_q;
        if (grant && !fe_ack) begin
            outst_d = outst_q + 1'b1;
        end else if (fe_ack && !grant) begin
            outst_d = outst_q - 1'b1;
        end

        // A grant in the redirect cycle belongs to the new path, so only
        // requests already in flight (minus one returning now) are dropped.
        drop_d = drop_q;
        if (pc_wen) begin
            drop_d = outst_q - CW'(fe_ack);
        end else if (drop_ack) begin
            drop_d = drop_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    // Tag FIFO tracks every granted address, stale or not, so it stays aligned
    // with the response stream; it is therefore never flushed on redirect.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .flush_i (1'b0),
        .push_i  (grant),
        .data_i  (cur_pc),
        .pop_i   (fe_ack),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (tag_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_insn_queue (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .flush_i (pc_wen),
        .push_i  (q_push),
        .data_i  (q_entry),
        .pop_i   (q_pop),
        .data_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign unused_status = ^{tag_full, tag_empty, tag_count, q_full};

    assign de_valid = ~q_empty;
    assign de_insn  = q_head.insn;
    assign de_pc    = q_head.pc;

endmodule
